// File: rtl/platform_lander_pkg.sv
// rtl/platform_lander_pkg.sv - shared state encodings and screen constants for the platform lander
package platform_lander_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STAND = 3'd1,
    ST_JUMP  = 3'd2,
    ST_FALL  = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  // Vertical geometry (pixel rows, 10-bit screen coordinates)
  localparam logic [9:0]  PLAT_ROW    = 10'd400;
  localparam logic [9:0]  BUG_H       = 10'd16;
  localparam logic [9:0]  START_ROW   = PLAT_ROW - BUG_H;
  localparam logic [9:0]  FLOOR_ROW   = 10'd472;
  localparam logic [9:0]  STEP        = 10'd2;

  // Horizontal geometry, widened to the 16-bit span arithmetic
  localparam logic [15:0] BUG_W       = 16'd16;
  localparam logic [15:0] MIN_W       = 16'd64;

  localparam logic [4:0]  JUMP_FRAMES = 5'd24;

endpackage

// File: rtl/platform_span.sv
// rtl/platform_span.sv - per-frame platform extent snapshot and bug/platform overlap test
module platform_span
  import platform_lander_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Frame,
  input  logic [14:0] Hupper,
  input  logic [5:0]  rand_lo,
  input  logic [9:0]  bugH,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        overlap
);

  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic [15:0] bug_lo, bug_hi;

  // Capture the platform's left and right edges on the frame pulse; 16 bits so the sum never wraps
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    if (Frame) begin
      left_d  = {1'b0, Hupper};
      right_d = {1'b0, Hupper} + MIN_W + {10'd0, rand_lo} - 16'd1;
    end
  end

  // Snapshot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_q  <= 16'd0;
      right_q <= 16'd0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Bug's horizontal extent intersects the snapshotted platform span
  always_comb begin
    bug_lo  = {6'd0, bugH};
    bug_hi  = bug_lo + BUG_W - 16'd1;
    overlap = (bug_hi >= left_q) && (bug_lo <= right_q);
  end

  assign left  = left_q;
  assign right = right_q;

endmodule

// File: rtl/platform_lander.sv
// rtl/platform_lander.sv - bug vertical-motion FSM: stand, jump, fall, land or die
module platform_lander
  import platform_lander_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Frame,
  input  logic        start,
  input  logic        jump,
  input  logic [9:0]  bugH,
  input  logic [14:0] Hupper,
  input  logic [14:0] rand_val,
  output logic        platformDW,
  output logic [9:0]  bugV,
  output logic        onPlatform,
  output logic        falling,
  output logic        dead
);

  state_e      state_q, state_d;
  logic [9:0]  bugv_q, bugv_d;
  logic [4:0]  jcnt_q, jcnt_d;
  logic        tick_q, tick_d;
  logic [9:0]  bugv_up, bugv_dn;
  logic        overlap;
  logic [15:0] span_left, span_right;
  logic        unused_bits;

  platform_span u_span (
    .clk     (clk),
    .reset   (reset),
    .Frame   (Frame),
    .Hupper  (Hupper),
    .rand_lo (rand_val[5:0]),
    .bugH    (bugH),
    .left    (span_left),
    .right   (span_right),
    .overlap (overlap)
  );

  assign unused_bits = ^{rand_val[14:6], span_left, span_right};

  // Next-state and motion: physics advances only on tick, start acts on any cycle
  always_comb begin
    state_d = state_q;
    bugv_d  = bugv_q;
    jcnt_d  = jcnt_q;
    tick_d  = Frame;
    bugv_up = (bugv_q >= STEP) ? (bugv_q - STEP) : 10'd0;
    bugv_dn = bugv_q + STEP;
    case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (start) begin
          state_d = ST_STAND;
          bugv_d  = START_ROW;
          jcnt_d  = 5'd0;
        end
      end
      ST_STAND: begin
        if (tick_q) begin
          if (jump) begin
            state_d = ST_JUMP;
            jcnt_d  = JUMP_FRAMES;
          end else if (!overlap) begin
            state_d = ST_FALL;
          end
        end
      end
      ST_JUMP: begin
        if (tick_q) begin
          bugv_d = bugv_up;
          jcnt_d = jcnt_q - 5'd1;
          if (jcnt_q <= 5'd1) begin
            state_d = ST_FALL;
            jcnt_d  = 5'd0;
          end
        end
      end
      ST_FALL: begin
        if (tick_q) begin
          if (overlap && (bugv_dn >= START_ROW) && (bugv_q <= START_ROW)) begin
            bugv_d  = START_ROW;
            state_d = ST_STAND;
          end else begin
            bugv_d = bugv_dn;
            if (bugv_dn >= FLOOR_ROW) begin
              state_d = ST_DEAD;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, position, jump counter and frame tick registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bugv_q  <= START_ROW;
      jcnt_q  <= 5'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bugv_q  <= bugv_d;
      jcnt_q  <= jcnt_d;
      tick_q  <= tick_d;
    end
  end

  assign bugV       = bugv_q;
  assign onPlatform = (state_q == ST_STAND);
  assign falling    = (state_q == ST_FALL);
  assign dead       = (state_q == ST_DEAD);
  assign platformDW = (state_q == ST_STAND) || (state_q == ST_JUMP) || (state_q == ST_FALL);

endmodule

// File: tb/tb_platform_lander.sv
// tb/tb_platform_lander.sv - scoreboard bench for the platform lander
module tb_platform_lander;

  logic        clk = 1'b0;
  logic        reset;
  logic        Frame;
  logic        start;
  logic        jump;
  logic [9:0]  bugH;
  logic [14:0] Hupper;
  logic [14:0] rand_val;
  logic        platformDW;
  logic [9:0]  bugV;
  logic        onPlatform;
  logic        falling;
  logic        dead;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string name;
    string sig;
    int    val;
  } exp_t;

  exp_t sb_q[$];

  platform_lander dut (
    .clk        (clk),
    .reset      (reset),
    .Frame      (Frame),
    .start      (start),
    .jump       (jump),
    .bugH       (bugH),
    .Hupper     (Hupper),
    .rand_val   (rand_val),
    .platformDW (platformDW),
    .bugV       (bugV),
    .onPlatform (onPlatform),
    .falling    (falling),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int observe(input string sig);
    if (sig == "bugV") return int'(bugV);
    if (sig == "onPlat") return int'(onPlatform);
    if (sig == "fall") return int'(falling);
    if (sig == "dead") return int'(dead);
    if (sig == "dw") return int'(platformDW);
    return -1;
  endfunction

  task automatic expect_val(input string name, input string sig, input int val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic expect_flags(input string name, input int on_p, input int fl, input int dd, input int dw);
    expect_val({name, "_onplat"}, "onPlat", on_p);
    expect_val({name, "_fall"}, "fall", fl);
    expect_val({name, "_dead"}, "dead", dd);
    expect_val({name, "_dw"}, "dw", dw);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.name, observe(e.sig), e.val);
    end
  endtask

  // One frame pulse; returns on the negedge after the FSM has consumed the tick
  task automatic frame();
    Frame = 1'b1;
    @(negedge clk);
    Frame = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Frame = 1'b0; start = 1'b0; jump = 1'b0;
    bugH = 10'd120; Hupper = 15'd100; rand_val = 15'd0;
    @(negedge clk);
    @(negedge clk);
    expect_val("rst_bugv", "bugV", 384);
    expect_flags("rst", 0, 0, 0, 0);
    drain();

    reset = 1'b0;
    @(negedge clk);
    expect_flags("idle_hold", 0, 0, 0, 0);
    drain();

    pulse_start();
    expect_val("start_bugv", "bugV", 384);
    expect_flags("start", 1, 0, 0, 1);
    drain();

    for (int i = 0; i < 3; i++) begin
      expect_val("stand_bugv", "bugV", 384);
      expect_flags("stand", 1, 0, 0, 1);
      frame();
      drain();
    end

    // Jump over a platform and land back on it
    jump = 1'b1;
    expect_val("jump_entry_bugv", "bugV", 384);
    expect_flags("jump_entry", 0, 0, 0, 1);
    frame();
    drain();
    jump = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      expect_val("jump_up_bugv", "bugV", 384 - 2 * k);
      frame();
      drain();
    end
    expect_flags("jump_apex", 0, 1, 0, 1);
    drain();
    for (int k = 1; k <= 24; k++) begin
      expect_val("jump_down_bugv", "bugV", (k == 24) ? 384 : 336 + 2 * k);
      frame();
      drain();
    end
    expect_flags("landed", 1, 0, 0, 1);
    drain();

    // Walk off the platform edge and fall to the floor
    Hupper = 15'd200;
    expect_val("edge_bugv", "bugV", 384);
    expect_flags("edge", 0, 1, 0, 1);
    frame();
    drain();
    for (int k = 1; k <= 44; k++) begin
      expect_val("fall_bugv", "bugV", 384 + 2 * k);
      frame();
      drain();
    end
    expect_flags("floor", 0, 0, 1, 0);
    drain();
    for (int k = 0; k < 2; k++) begin
      expect_val("dead_hold_bugv", "bugV", 472);
      expect_val("dead_hold", "dead", 1);
      frame();
      drain();
    end
    pulse_start();
    expect_val("restart_bugv", "bugV", 384);
    expect_flags("restart", 1, 0, 0, 1);
    drain();

    // Jump wins over falling off an edge on the same tick
    jump = 1'b1;
    expect_flags("prio", 0, 0, 0, 1);
    frame();
    drain();
    jump = 1'b0;
    expect_val("prio_bugv", "bugV", 382);
    frame();
    drain();
    for (int k = 2; k <= 24; k++) begin
      expect_val("prio_up_bugv", "bugV", 384 - 2 * k);
      frame();
      drain();
    end
    expect_val("prio_apex", "fall", 1);
    drain();
    for (int k = 1; k <= 47; k++) begin
      expect_val("prio_fall_bugv", "bugV", 336 + 2 * k);
      frame();
      drain();
    end
    expect_val("pre_reset_fall", "fall", 1);
    drain();

    // Asynchronous reset mid-fall at row 430
    reset = 1'b1;
    #1;
    expect_val("async_rst_bugv", "bugV", 384);
    expect_flags("async_rst", 0, 0, 0, 0);
    drain();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Frame together with start: snapshot loads and the next tick sees the platform
    Hupper = 15'd100;
    start = 1'b1;
    Frame = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Frame = 1'b0;
    @(negedge clk);
    expect_val("frame_start_bugv", "bugV", 384);
    expect_flags("frame_start", 1, 0, 0, 1);
    drain();

    // Random span length widens the platform enough to keep standing
    Hupper = 15'd80;
    rand_val = 15'h7FC0 | 15'd40;
    bugH = 10'd180;
    expect_flags("rand_span", 1, 0, 0, 1);
    frame();
    drain();
    bugH = 10'd185;
    expect_flags("rand_span_edge", 0, 1, 0, 1);
    frame();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
